// File: rtl/processor_sys_clk_timer_driver.sv
// Avalon-MM initiator that programs the system clock timer, services its IRQ and counts ticks.
// Snapshot read-back is optional: define PROCESSOR_SYS_CLK_TIMER_DRIVER_SNAPSHOT_EN to enable it.
module processor_sys_clk_timer_driver #(
    parameter bit DEFAULT_CONT = 1'b1,
    parameter bit TIE_CONT     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] period,
    input  logic        continuous,
    output logic        busy,
    output logic        running,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    input  logic        timer_irq,
    input  logic        snap_req,
    output logic        snap_valid,
    output logic [31:0] snap_value
);

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTL,
        RUN,
        CLR_STS,
        WR_STOP,
        STOP_CLR
`ifdef PROCESSOR_SYS_CLK_TIMER_DRIVER_SNAPSHOT_EN
        ,
        SNAP_WR,
        SNAP_RL,
        SNAP_RLC,
        SNAP_RHC
`endif
    } state_t;

    state_t      state;
    logic [15:0] period_hi;
    logic        cont;

`ifndef PROCESSOR_SYS_CLK_TIMER_DRIVER_SNAPSHOT_EN
    logic unused_inputs;
    assign unused_inputs = ^{snap_req, av_readdata};
    assign snap_valid    = 1'b0;
    assign snap_value    = 32'h0;
`endif

    // Bus outputs are registered against the state being entered, so each
    // write state owns exactly the one cycle it is resident.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            period_hi     <= 16'h0;
            cont          <= 1'b0;
            busy          <= 1'b0;
            running       <= 1'b0;
            tick          <= 1'b0;
            tick_count    <= 16'h0;
            av_address    <= 3'd0;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_writedata  <= 16'h0;
`ifdef PROCESSOR_SYS_CLK_TIMER_DRIVER_SNAPSHOT_EN
            snap_valid    <= 1'b0;
            snap_value    <= 32'h0;
`endif
        end else begin
            tick          <= 1'b0;
            av_address    <= 3'd0;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_writedata  <= 16'h0;
`ifdef PROCESSOR_SYS_CLK_TIMER_DRIVER_SNAPSHOT_EN
            snap_valid    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        period_hi     <= period[31:16];
                        cont          <= TIE_CONT ? DEFAULT_CONT : continuous;
                        state         <= WR_PL;
                        busy          <= 1'b1;
                        av_address    <= 3'd2;
                        av_chipselect <= 1'b1;
                        av_write_n    <= 1'b0;
                        av_writedata  <= period[15:0];
                    end
                end
                WR_PL: begin
                    state         <= WR_PH;
                    av_address    <= 3'd3;
                    av_chipselect <= 1'b1;
                    av_write_n    <= 1'b0;
                    av_writedata  <= period_hi;
                end
                WR_PH: begin
                    // Control word: STOP=0, START=1, CONT, ITO=1.
                    state         <= WR_CTL;
                    av_address    <= 3'd1;
                    av_chipselect <= 1'b1;
                    av_write_n    <= 1'b0;
                    av_writedata  <= {12'h0, 1'b0, 1'b1, cont, 1'b1};
                end
                WR_CTL: begin
                    state   <= RUN;
                    busy    <= 1'b0;
                    running <= 1'b1;
                end
                RUN: begin
                    if (stop) begin
                        state         <= WR_STOP;
                        busy          <= 1'b1;
                        running       <= 1'b0;
                        av_address    <= 3'd1;
                        av_chipselect <= 1'b1;
                        av_write_n    <= 1'b0;
                        av_writedata  <= 16'h0008;
                    end else if (timer_irq) begin
                        state         <= CLR_STS;
                        busy          <= 1'b1;
                        running       <= 1'b0;
                        tick          <= 1'b1;
                        tick_count    <= tick_count + 16'd1;
                        av_address    <= 3'd0;
                        av_chipselect <= 1'b1;
                        av_write_n    <= 1'b0;
                    end
`ifdef PROCESSOR_SYS_CLK_TIMER_DRIVER_SNAPSHOT_EN
                    else if (snap_req) begin
                        state         <= SNAP_WR;
                        busy          <= 1'b1;
                        running       <= 1'b0;
                        av_address    <= 3'd4;
                        av_chipselect <= 1'b1;
                        av_write_n    <= 1'b0;
                    end
`endif
                end
                CLR_STS: begin
                    state   <= cont ? RUN : IDLE;
                    busy    <= 1'b0;
                    running <= cont;
                end
                WR_STOP: begin
                    state         <= STOP_CLR;
                    av_address    <= 3'd0;
                    av_chipselect <= 1'b1;
                    av_write_n    <= 1'b0;
                end
                STOP_CLR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`ifdef PROCESSOR_SYS_CLK_TIMER_DRIVER_SNAPSHOT_EN
                // readdata lags the address by one cycle, so address 5 is
                // presented while the low half is being captured.
                SNAP_WR: begin
                    state      <= SNAP_RL;
                    av_address <= 3'd4;
                end
                SNAP_RL: begin
                    state      <= SNAP_RLC;
                    av_address <= 3'd5;
                end
                SNAP_RLC: begin
                    state            <= SNAP_RHC;
                    snap_value[15:0] <= av_readdata;
                    av_address       <= 3'd5;
                end
                SNAP_RHC: begin
                    state             <= RUN;
                    snap_value[31:16] <= av_readdata;
                    snap_valid        <= 1'b1;
                    busy              <= 1'b0;
                    running           <= 1'b1;
                end
`endif
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_processor_sys_clk_timer_driver.sv
// Directed bench for processor_sys_clk_timer_driver with a small registered timer model.
module tb_processor_sys_clk_timer_driver;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] period;
    logic        continuous;
    logic        busy;
    logic        running;
    logic        tick;
    logic [15:0] tick_count;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        timer_irq;
    logic        snap_req;
    logic        snap_valid;
    logic [31:0] snap_value;

    int total;
    int bad;

    logic        irq_q;
    logic        irq_set;
    logic        irq_hold;
    logic [31:0] model_cnt;
    logic [31:0] snap_reg;
    int          tick_seen;

    processor_sys_clk_timer_driver dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .period       (period),
        .continuous   (continuous),
        .busy         (busy),
        .running      (running),
        .tick         (tick),
        .tick_count   (tick_count),
        .av_address   (av_address),
        .av_chipselect(av_chipselect),
        .av_write_n   (av_write_n),
        .av_writedata (av_writedata),
        .av_readdata  (av_readdata),
        .timer_irq    (timer_irq),
        .snap_req     (snap_req),
        .snap_valid   (snap_valid),
        .snap_value   (snap_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timer model: irq falls on the status write, snapshot latched on the addr-4 write,
    // readdata registered one cycle behind the address.
    always @(posedge clk) begin
        if (reset) begin
            irq_q       <= 1'b0;
            snap_reg    <= 32'h0;
            av_readdata <= 16'h0;
        end else begin
            if (irq_set)
                irq_q <= 1'b1;
            else if (av_chipselect && !av_write_n && av_address == 3'd0)
                irq_q <= 1'b0;
            if (av_chipselect && !av_write_n && av_address == 3'd4)
                snap_reg <= model_cnt;
            case (av_address)
                3'd4:    av_readdata <= snap_reg[15:0];
                3'd5:    av_readdata <= snap_reg[31:16];
                default: av_readdata <= 16'h0;
            endcase
        end
    end
    assign timer_irq = irq_q | irq_hold;

    always @(negedge clk) begin
        if (reset)
            tick_seen <= 0;
        else if (tick)
            tick_seen <= tick_seen + 1;
    end

    task test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({av_address, av_chipselect, av_write_n, av_writedata} !== {3'd0, 1'b0, 1'b1, 16'h0}) begin
            bad++;
            $display("FAIL reset_bus got a=%0d cs=%b wn=%b d=%h exp a=0 cs=0 wn=1 d=0000",
                     av_address, av_chipselect, av_write_n, av_writedata);
        end
        total++;
        if ({busy, running, tick} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got busy=%b run=%b tick=%b exp 0 0 0", busy, running, tick);
        end
        total++;
        if (tick_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_count got %h exp 0000", tick_count);
        end
        total++;
        if ({snap_valid, snap_value} !== 33'd0) begin
            bad++;
            $display("FAIL reset_snap got v=%b val=%h exp 0 00000000", snap_valid, snap_value);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Start a programming sequence and check the three writes plus entry to RUN.
    task test_start(input logic [31:0] per, input logic cnt, input logic [15:0] ctl, input string nm);
        logic [2:0]  ea [0:2];
        logic [15:0] ed [0:2];
        ea[0] = 3'd2; ed[0] = per[15:0];
        ea[1] = 3'd3; ed[1] = per[31:16];
        ea[2] = 3'd1; ed[2] = ctl;
        period = per;
        continuous = cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        period = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if ({av_chipselect, av_write_n, av_address, av_writedata, busy} !== {1'b1, 1'b0, ea[i], ed[i], 1'b1}) begin
                bad++;
                $display("FAIL %s_wr%0d got cs=%b wn=%b a=%0d d=%h busy=%b exp cs=1 wn=0 a=%0d d=%h busy=1",
                         nm, i, av_chipselect, av_write_n, av_address, av_writedata, busy, ea[i], ed[i]);
            end
        end
        @(negedge clk);
        total++;
        if ({running, busy, av_chipselect, av_write_n} !== 4'b1001) begin
            bad++;
            $display("FAIL %s_run got run=%b busy=%b cs=%b wn=%b exp 1 0 0 1", nm, running, busy, av_chipselect, av_write_n);
        end
    endtask

    task test_irq_service(input logic [15:0] exp_cnt, input logic exp_run, input string nm);
        int t0;
        t0 = tick_seen;
        irq_set = 1'b1;
        @(negedge clk);
        irq_set = 1'b0;
        @(negedge clk);
        total++;
        if ({av_chipselect, av_write_n, av_address, av_writedata, tick, tick_count} !==
            {1'b1, 1'b0, 3'd0, 16'h0, 1'b1, exp_cnt}) begin
            bad++;
            $display("FAIL %s_clr got cs=%b wn=%b a=%0d d=%h tick=%b cnt=%h exp 1 0 0 0000 1 %h",
                     nm, av_chipselect, av_write_n, av_address, av_writedata, tick, tick_count, exp_cnt);
        end
        @(negedge clk);
        total++;
        if ({running, busy, tick, timer_irq, av_chipselect} !== {exp_run, 4'b0000}) begin
            bad++;
            $display("FAIL %s_after got run=%b busy=%b tick=%b irq=%b cs=%b exp run=%b others 0",
                     nm, running, busy, tick, timer_irq, av_chipselect, exp_run);
        end
        repeat (3) @(negedge clk);
        total++;
        if (tick_count !== exp_cnt || tick_seen != t0 + 1) begin
            bad++;
            $display("FAIL %s_single got cnt=%h ticks=%0d exp cnt=%h ticks=%0d", nm, tick_count, tick_seen - t0, exp_cnt, 1);
        end
    endtask

    task test_stop_irq(input logic [15:0] exp_cnt);
        int t0;
        t0 = tick_seen;
        irq_set = 1'b1;
        @(negedge clk);
        irq_set = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++;
        if ({av_chipselect, av_write_n, av_address, av_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0008}) begin
            bad++;
            $display("FAIL stop_wr got cs=%b wn=%b a=%0d d=%h exp 1 0 1 0008", av_chipselect, av_write_n, av_address, av_writedata);
        end
        @(negedge clk);
        total++;
        if ({av_chipselect, av_write_n, av_address, av_writedata, tick} !== {1'b1, 1'b0, 3'd0, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL stop_clr got cs=%b wn=%b a=%0d d=%h tick=%b exp 1 0 0 0000 0",
                     av_chipselect, av_write_n, av_address, av_writedata, tick);
        end
        @(negedge clk);
        total++;
        if ({busy, running, av_chipselect, timer_irq} !== 4'b0000 || tick_count !== exp_cnt || tick_seen != t0) begin
            bad++;
            $display("FAIL stop_idle got busy=%b run=%b cs=%b irq=%b cnt=%h ticks=%0d exp 0 0 0 0 cnt=%h ticks=0",
                     busy, running, av_chipselect, timer_irq, tick_count, tick_seen - t0, exp_cnt);
        end
    endtask

    // stop in IDLE, start/stop during programming and start in RUN are all dropped.
    task test_dropped;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++;
        if ({busy, running, av_chipselect} !== 3'b000) begin
            bad++;
            $display("FAIL drop_idle got busy=%b run=%b cs=%b exp 0 0 0", busy, running, av_chipselect);
        end
        period = 32'h0000_0100;
        continuous = 1'b1;
        start = 1'b1;
        @(negedge clk);
        stop = 1'b1;
        period = 32'hFFFF_FFFF;
        continuous = 1'b0;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        total++;
        if ({av_chipselect, av_address, av_writedata} !== {1'b1, 3'd1, 16'h0007}) begin
            bad++;
            $display("FAIL drop_busy got cs=%b a=%0d d=%h exp 1 1 0007", av_chipselect, av_address, av_writedata);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if ({running, busy, av_chipselect} !== 3'b100) begin
            bad++;
            $display("FAIL drop_run got run=%b busy=%b cs=%b exp 1 0 0", running, busy, av_chipselect);
        end
    endtask

`ifdef PROCESSOR_SYS_CLK_TIMER_DRIVER_SNAPSHOT_EN
    task test_snapshot(input logic [31:0] val);
        model_cnt = val;
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        total++;
        if ({av_chipselect, av_write_n, av_address, av_writedata, busy} !== {1'b1, 1'b0, 3'd4, 16'h0, 1'b1}) begin
            bad++;
            $display("FAIL snap_wr got cs=%b wn=%b a=%0d d=%h busy=%b exp 1 0 4 0000 1",
                     av_chipselect, av_write_n, av_address, av_writedata, busy);
        end
        @(negedge clk);
        total++;
        if ({av_chipselect, av_address, snap_valid} !== {1'b0, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL snap_rl got cs=%b a=%0d v=%b exp 0 4 0", av_chipselect, av_address, snap_valid);
        end
        @(negedge clk);
        total++;
        if ({av_chipselect, av_address, snap_valid} !== {1'b0, 3'd5, 1'b0}) begin
            bad++;
            $display("FAIL snap_rh got cs=%b a=%0d v=%b exp 0 5 0", av_chipselect, av_address, snap_valid);
        end
        @(negedge clk);
        total++;
        if (snap_valid !== 1'b0) begin
            bad++;
            $display("FAIL snap_early got v=%b exp 0", snap_valid);
        end
        @(negedge clk);
        total++;
        if ({snap_valid, snap_value, running} !== {1'b1, val, 1'b1}) begin
            bad++;
            $display("FAIL snap_val got v=%b val=%h run=%b exp 1 %h 1", snap_valid, snap_value, running, val);
        end
        @(negedge clk);
        total++;
        if (snap_valid !== 1'b0) begin
            bad++;
            $display("FAIL snap_pulse got v=%b exp 0", snap_valid);
        end
    endtask
`else
    task test_snap_ignored;
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({running, busy, av_chipselect, snap_valid, snap_value} !== {3'b100, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL snap_ign got run=%b busy=%b cs=%b v=%b val=%h exp 1 0 0 0 00000000",
                     running, busy, av_chipselect, snap_valid, snap_value);
        end
    endtask
`endif

    // A stuck irq gives one service every two cycles; release it once the count reads FFFF.
    task test_wrap;
        logic done;
        done = 1'b0;
        irq_hold = 1'b1;
        for (int i = 0; i < 140000 && !done; i++) begin
            @(negedge clk);
            if (tick_count === 16'hFFFF) done = 1'b1;
        end
        irq_hold = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wrap_timeout got cnt=%h exp reach ffff", tick_count);
        end
        repeat (2) @(negedge clk);
        total++;
        if ({running, tick_count} !== {1'b1, 16'hFFFF}) begin
            bad++;
            $display("FAIL wrap_preset got run=%b cnt=%h exp 1 ffff", running, tick_count);
        end
        test_irq_service(16'h0000, 1'b1, "wrap");
    endtask

    task test_reset_mid;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        period = 32'h0000_2000;
        continuous = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if ({av_chipselect, av_write_n, av_writedata, busy} !== {1'b0, 1'b1, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid got cs=%b wn=%b d=%h busy=%b exp 0 1 0000 0", av_chipselect, av_write_n, av_writedata, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        period = 32'h0;
        continuous = 1'b0;
        snap_req = 1'b0;
        irq_set = 1'b0;
        irq_hold = 1'b0;
        model_cnt = 32'h0;

        test_reset;
        test_start(32'h0001_86A0, 1'b1, 16'h0007, "start_cont");
        test_irq_service(16'h0001, 1'b1, "irq1");
        test_irq_service(16'h0002, 1'b1, "irq2");
        test_stop_irq(16'h0002);
        test_start(32'h0000_0010, 1'b0, 16'h0005, "start_once");
        test_irq_service(16'h0003, 1'b0, "oneshot");
        test_dropped;
`ifdef PROCESSOR_SYS_CLK_TIMER_DRIVER_SNAPSHOT_EN
        test_snapshot(32'h0000_C000);
        test_snapshot(32'h1234_ABCD);
`else
        test_snap_ignored;
`endif
        test_wrap;
        test_reset_mid;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got no completion exp summary before time limit");
        $fatal(1);
    end

endmodule
